// File: rtl/card_lock_pkg.sv
// Shared types and the guest-code LFSR step for the card lock controller.
package card_lock_pkg;

    typedef enum logic [1:0] {
        GUEST    = 2'b00,
        MAID     = 2'b01,
        MANAGER  = 2'b10,
        RESERVED = 2'b11
    } card_type_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        UNLOCKED = 2'b01,
        LOCKOUT  = 2'b10
    } lock_state_t;

    localparam int LFSR_MAX_W = 64;

    // Width-agnostic step: shift left, feed parity of tapped bits into bit 0.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] c,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    w
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic                  fb;
        mask = (w >= LFSR_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
        fb   = ^(c & taps & mask);
        return ((c << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & mask;
    endfunction

endpackage

// File: rtl/guest_code_lfsr.sv
// Holds the rolling guest code; presents current and next value, advances on load_next.
module guest_code_lfsr
    import card_lock_pkg::*;
#(
    parameter int                CODE_W     = 16,
    parameter logic [CODE_W-1:0] LFSR_TAPS  = 16'hB400,
    parameter logic [CODE_W-1:0] GUEST_SEED = 16'h0001
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_next,
    output logic [CODE_W-1:0] code,
    output logic [CODE_W-1:0] code_next
);

    assign code_next = CODE_W'(lfsr_next(LFSR_MAX_W'(code), LFSR_MAX_W'(LFSR_TAPS), CODE_W));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            code <= GUEST_SEED;
        else if (load_next)
            code <= code_next;
    end

endmodule

// File: rtl/card_lock_controller.sv
// Card lock FSM: validates reads, times the latch, counts consecutive failures into lockout.
module card_lock_controller
    import card_lock_pkg::*;
#(
    parameter int                CODE_W         = 16,
    parameter logic [CODE_W-1:0] LFSR_TAPS      = 16'hB400,
    parameter logic [CODE_W-1:0] GUEST_SEED     = 16'h0001,
    parameter logic [CODE_W-1:0] MAID_CODE      = 16'h5A5A,
    parameter logic [CODE_W-1:0] MANAGER_CODE   = 16'hC3C3,
    parameter int                UNLOCK_CYCLES  = 1000,
    parameter int                MAX_FAILS      = 3,
    parameter int                LOCKOUT_CYCLES = 5000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              card_read,
    input  logic [1:0]        card_type,
    input  logic [CODE_W-1:0] entry_code_on_card,
    input  logic              trip_lock_for_guest,
    output logic              unlock,
    output logic              card_rejected,
    output logic              locked_out,
    output logic [CODE_W-1:0] guest_code
);

    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);

    lock_state_t       state;
    logic [TMR_W-1:0]  timer;
    logic [FAIL_W-1:0] fail_cnt;
    logic [CODE_W-1:0] code_next;
    card_type_t        ctype;
    logic              accept, count_fail, advance, mgr_ok, load_next;

    assign ctype  = card_type_t'(card_type);
    assign mgr_ok = (ctype == MANAGER) && (entry_code_on_card == MANAGER_CODE);

    // Tripped guest/maid reads are refused without counting toward lockout.
    always_comb begin
        accept     = 1'b0;
        count_fail = 1'b0;
        advance    = 1'b0;
        case (ctype)
            GUEST: begin
                if (!trip_lock_for_guest) begin
                    if (entry_code_on_card == guest_code)
                        accept = 1'b1;
                    else if (entry_code_on_card == code_next) begin
                        accept  = 1'b1;
                        advance = 1'b1;
                    end else
                        count_fail = 1'b1;
                end
            end
            MAID: begin
                if (!trip_lock_for_guest) begin
                    if (entry_code_on_card == MAID_CODE)
                        accept = 1'b1;
                    else
                        count_fail = 1'b1;
                end
            end
            MANAGER: begin
                if (mgr_ok)
                    accept = 1'b1;
                else
                    count_fail = 1'b1;
            end
            default: count_fail = 1'b1;
        endcase
    end

    assign load_next = card_read && (state != LOCKOUT) && advance;

    guest_code_lfsr #(
        .CODE_W     (CODE_W),
        .LFSR_TAPS  (LFSR_TAPS),
        .GUEST_SEED (GUEST_SEED)
    ) u_guest_code (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_next (load_next),
        .code      (guest_code),
        .code_next (code_next)
    );

    // Timer countdown is written first; a card decision in the same cycle overrides it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            timer         <= '0;
            fail_cnt      <= '0;
            unlock        <= 1'b0;
            card_rejected <= 1'b0;
            locked_out    <= 1'b0;
        end else begin
            card_rejected <= 1'b0;
            if (state != IDLE) begin
                if (timer <= TMR_W'(1)) begin
                    state      <= IDLE;
                    timer      <= '0;
                    unlock     <= 1'b0;
                    locked_out <= 1'b0;
                end else
                    timer <= timer - 1'b1;
            end
            if (card_read) begin
                if ((state == LOCKOUT) ? mgr_ok : accept) begin
                    state      <= UNLOCKED;
                    timer      <= TMR_W'(UNLOCK_CYCLES);
                    fail_cnt   <= '0;
                    unlock     <= 1'b1;
                    locked_out <= 1'b0;
                end else begin
                    card_rejected <= 1'b1;
                    if (state != LOCKOUT && count_fail) begin
                        if (fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
                            state      <= LOCKOUT;
                            timer      <= TMR_W'(LOCKOUT_CYCLES);
                            fail_cnt   <= '0;
                            unlock     <= 1'b0;
                            locked_out <= 1'b1;
                        end else
                            fail_cnt <= fail_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/card_lock_controller.md
# card_lock_controller

Clocked, parametrised successor to the lab electronic card lock: it validates swiped cards against a rolling guest code, a maid code and a manager code, and drives the door latch. The guest code advances through an LFSR sequence on check-in of a new guest. The block adds timed unlock, a consecutive-failure lockout and guest deadbolt override. It sits between the card-reader front end (which presents a one-cycle read strobe) and the latch driver.

## Interface
Parameters:
- CODE_W, 16, width of card and stored codes (≥ 4)
- LFSR_TAPS, 16'hB400, feedback tap mask, CODE_W bits
- GUEST_SEED, 16'h0001, guest code after reset; must be nonzero
- MAID_CODE, 16'h5A5A, fixed maid code
- MANAGER_CODE, 16'hC3C3, fixed manager code
- UNLOCK_CYCLES, 1000, latch-open duration in clocks (≥ 1)
- MAX_FAILS, 3, consecutive failures that trigger lockout (≥ 1)
- LOCKOUT_CYCLES, 5000, lockout duration in clocks (≥ 1)

Ports:
- clk  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- card_read  in  1  one-cycle strobe: card fields valid this cycle
- card_type  in  2  00 guest, 01 maid, 10 manager, 11 reserved
- entry_code_on_card  in  CODE_W  code read from card
- trip_lock_for_guest  in  1  level; deadbolt set from inside
- unlock  out  1  latch open
- card_rejected  out  1  one-cycle pulse per rejected read
- locked_out  out  1  high during lockout
- guest_code  out  CODE_W  current stored guest code

## Operation
- next(c) = {c[CODE_W-2:0], ^(c & LFSR_TAPS)}.
- States: IDLE, UNLOCKED, LOCKOUT. Reset → IDLE, unlock 0, card_rejected 0, locked_out 0, guest_code GUEST_SEED, fail count 0, timer 0.
- Decision on a card_read in IDLE or UNLOCKED:
  - guest, not tripped, code == guest_code → accept.
  - guest, not tripped, code == next(guest_code) → accept; guest_code ← next(guest_code) (new guest; old card invalid).
  - guest while tripped → reject, fail count unchanged.
  - maid, code == MAID_CODE, not tripped → accept; maid while tripped → reject, fail count unchanged.
  - manager, code == MANAGER_CODE → accept regardless of trip.
  - reserved type, or any other code mismatch → reject, fail count +1.
- Accept: state UNLOCKED, timer loaded to UNLOCK_CYCLES, fail count cleared. Accept while already UNLOCKED restarts the timer.
- Reject with fail count reaching MAX_FAILS: state LOCKOUT, timer loaded to LOCKOUT_CYCLES, fail count cleared, unlock 0.
- UNLOCKED: timer decrements each cycle; on reaching 0 → IDLE. Assertion of trip_lock_for_guest does not close an open latch.
- LOCKOUT: only a valid manager card is honoured (→ UNLOCKED, locked_out 0); every other read → card_rejected, no counting. Timer expiry → IDLE.
- Only a guest accept modifies guest_code; guest_code is never 0 for a nonzero seed and maximal taps.

## Timing
- All decisions registered: card_read in cycle N → unlock / card_rejected / locked_out / guest_code change visible in cycle N+1.
- unlock high for exactly UNLOCK_CYCLES cycles after the last accept.
- locked_out high for exactly LOCKOUT_CYCLES cycles unless cleared by manager card.
- Back-to-back strobes (every cycle) are legal; each is decided independently against the state updated by its predecessor.
- card_read low: card_type and code are don't-care.
- reset_n low at any time, including mid-unlock or mid-lockout, immediately forces reset values; first decision possible on the first card_read after reset_n rises.

## Structure
- Package card_lock_pkg: card_type_t enum (GUEST, MAID, MANAGER, RESERVED), lock_state_t enum (IDLE, UNLOCKED, LOCKOUT), function lfsr_next.
- Sub-module guest_code_lfsr: holds guest_code, outputs current and next value, load-next enable, async reset to GUEST_SEED.
- Top holds FSM, shared down-counter (width from max of UNLOCK_CYCLES/LOCKOUT_CYCLES), fail counter.

## Test plan
(CODE_W 16, UNLOCK_CYCLES 4, MAX_FAILS 3, LOCKOUT_CYCLES 8, defaults otherwise)
- Reset, guest card 0x0001 → unlock high cycles N+1..N+4, guest_code stays 0x0001.
- Guest card 0x0002 (next) → unlock, guest_code 0x0002; then card 0x0001 → card_rejected pulse.
- trip high: guest 0x0001 and maid 0x5A5A rejected, no lockout after 3; manager 0xC3C3 → unlock.
- Three wrong codes 0x1234 → third causes locked_out for 8 cycles; guest 0x0001 during lockout rejected; manager clears it.
- Accept at cycle N, re-accept at N+2 → unlock continuously until N+6.
- reset_n low during UNLOCKED at cycle 2 → unlock 0 immediately, guest_code back to 0x0001.
